// File: rtl/fetch_pkg.sv
// fetch_pkg: shared entry type, PC increment and width helpers for the fetch stage.
package fetch_pkg;
    localparam int XLEN_DEF = 32;
    localparam int PC_INC   = 4;

    typedef struct packed {
        logic [XLEN_DEF-1:0] instr;
        logic [XLEN_DEF-1:0] pc;
    } fetch_entry_t;

    function automatic int ptr_w(int depth);
        return depth > 1 ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/fetch_if.sv
// fetch_if: redirect, instruction-memory and decode handshakes of the fetch stage.
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_pc_4;

    modport master (
        input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, id_ready,
        output imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_4
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, id_ready,
        input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_4
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO with flush; the head entry is presented combinationally.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter type T     = fetch_entry_t,
    parameter int  DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  T                        din_i,
    input  logic                    pop_i,
    input  logic                    flush_i,
    output T                        dout_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [cnt_w(DEPTH)-1:0] count_o
);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    T              mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] inc(logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = count_q == CW'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign dout_o  = mem_q[rptr_q];
    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wptr_d  = flush_i ? '0 : do_push ? inc(wptr_q) : wptr_q;
        rptr_d  = flush_i ? '0 : do_pop ? inc(rptr_q) : rptr_q;
        count_d = flush_i ? '0 : count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (do_push) mem_q[wptr_q] <= din_i;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential fetch with credit-limited imem requests, redirect flush and a decode queue.
// FETCH_BYPASS_EN: a response reaching an empty queue is forwarded to decode in the same cycle.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN            = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int              FQ_DEPTH        = 4,
    parameter int              MAX_OUTSTANDING = 4
) (
    input logic     clk,
    input logic     rst,
    fetch_if.master bus
);
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    localparam int OW = cnt_w(MAX_OUTSTANDING);
    localparam int QW = cnt_w(FQ_DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, pend_pc;
    logic [OW-1:0]   discard_q, discard_d, pend_count, outstanding;
    logic [QW-1:0]   q_count;
    logic            redirect, grant, accept, q_push, q_pop, q_empty, q_full, pend_full, pend_empty;
    entry_t          q_head, rsp, head;

    // Non-discarded requests live in the pending-PC FIFO, the rest are counted by discard_q.
    assign redirect      = bus.redirect_valid;
    assign outstanding   = pend_count + discard_q;
    assign bus.imem_req  = !rst && !redirect && (int'(q_count) + int'(outstanding) < FQ_DEPTH)
                           && (int'(outstanding) < MAX_OUTSTANDING);
    assign bus.imem_addr = fetch_pc_q;
    assign grant         = bus.imem_req && bus.imem_gnt;
    assign accept        = bus.imem_rvalid && !redirect && discard_q == '0;
    assign rsp           = '{instr: bus.imem_rdata, pc: pend_pc};

`ifdef FETCH_BYPASS_EN
    logic byp;
    assign byp          = accept && q_empty;
    assign head         = byp ? rsp : q_head;
    assign bus.id_valid = !q_empty || byp;
    assign q_push       = accept && !(byp && bus.id_ready);
`else
    assign head         = q_head;
    assign bus.id_valid = !q_empty;
    assign q_push       = accept;
`endif

    assign q_pop       = !q_empty && bus.id_ready;
    assign bus.id_instr = head.instr;
    assign bus.id_pc    = head.pc;
    assign bus.id_pc_4  = head.pc + XLEN'(PC_INC);

    always_comb begin
        fetch_pc_d = redirect ? bus.redirect_pc : grant ? fetch_pc_q + XLEN'(PC_INC) : fetch_pc_q;
        discard_d  = redirect ? outstanding - OW'(bus.imem_rvalid)
                   : (bus.imem_rvalid && discard_q != '0) ? discard_q - OW'(1) : discard_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
        end
    end

    fetch_queue #(.T(entry_t), .DEPTH(FQ_DEPTH)) u_fq (
        .clk(clk), .rst(rst), .push_i(q_push), .din_i(rsp), .pop_i(q_pop), .flush_i(redirect),
        .dout_o(q_head), .full_o(q_full), .empty_o(q_empty), .count_o(q_count)
    );

    fetch_queue #(.T(logic [XLEN-1:0]), .DEPTH(MAX_OUTSTANDING)) u_pend (
        .clk(clk), .rst(rst), .push_i(grant), .din_i(fetch_pc_q), .pop_i(accept), .flush_i(redirect),
        .dout_o(pend_pc), .full_o(pend_full), .empty_o(pend_empty), .count_o(pend_count)
    );

    assert property (@(posedge clk) disable iff (rst) !(q_push && q_full && !q_pop));
    assert property (@(posedge clk) disable iff (rst) !(grant && pend_full));
    assert property (@(posedge clk) disable iff (rst) !(accept && pend_empty));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench with an in-order imem responder and a decode-side scoreboard.
module tb_fetch_unit;
    localparam int          FQ     = 4;
    localparam int          MO     = 4;
    localparam logic [31:0] RST_PC = 32'h0;
`ifdef FETCH_BYPASS_EN
    localparam int FIRST = 2;
`else
    localparam int FIRST = 3;
`endif

    typedef struct {logic [31:0] pc; logic [31:0] instr;} exp_t;
    typedef struct {logic [31:0] addr; int epoch; int due;} req_t;

    logic clk = 0;
    logic rst = 1;
    fetch_if #(.XLEN(32)) bus();
    fetch_unit #(.XLEN(32), .RESET_PC(RST_PC), .FQ_DEPTH(FQ), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    always #5 clk = ~clk;

    exp_t        expq[$];
    logic [31:0] addrq[$];
    req_t        respq[$];
    int          checks = 0, errors = 0, cyc = 0, epoch = 0;
    logic [31:0] model_pc = RST_PC;
    logic        exp_req = 0, prev_redir = 0;
    int          p_gnt = 100, p_ready = 100, p_redir = 0, p_rv = 100, lat_min = 1, lat_max = 1;
    logic        force_redir = 0;
    logic [31:0] force_pc = 0;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit roll(int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t = $urandom & 32'hFFFF_FFFC;
        if (roll(25)) t = 32'hFFFF_FFF0 | (t & 32'hC);
        return t;
    endfunction

    function automatic int old_inflight();
        int n = 0;
        foreach (respq[i]) if (respq[i].epoch != epoch) n++;
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_hs(input string name, input logic [31:0] pc);
        bit seen = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk); #4;
            seen = bus.id_valid && bus.id_ready && !bus.redirect_valid;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: no decode handshake within 40 cycles", name);
        end else begin
            chk(name, bus.id_pc, pc);
            chk({name, "_pc4"}, bus.id_pc_4, pc + 32'd4);
        end
    endtask

    // Stimulus and imem responder; expectations are queued when a request is granted.
    initial begin
        bus.redirect_valid = 0; bus.redirect_pc = 0; bus.imem_gnt = 0;
        bus.imem_rvalid = 0; bus.imem_rdata = 0; bus.id_ready = 0;
        forever begin
            @(negedge clk); #1;
            cyc++;
            if (rst) begin
                expq.delete(); addrq.delete(); respq.delete();
                model_pc = RST_PC; epoch = 0; exp_req = 0;
                bus.redirect_valid = 0; bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.id_ready = 0;
            end else begin
                bus.redirect_valid = force_redir || roll(p_redir);
                bus.redirect_pc    = force_redir ? force_pc : rand_target();
                force_redir        = 0;
                bus.imem_gnt       = roll(p_gnt);
                bus.id_ready       = roll(p_ready);
                exp_req = !bus.redirect_valid && (expq.size() + old_inflight() < FQ) && (respq.size() < MO);
                bus.imem_rvalid = 0;
                if (respq.size() > 0 && respq[0].due <= cyc && roll(p_rv)) begin
                    bus.imem_rvalid = 1;
                    bus.imem_rdata  = mem_word(respq[0].addr);
                    void'(respq.pop_front());
                end
                #1;
                if (bus.imem_req && bus.imem_gnt) begin
                    expq.push_back('{model_pc, mem_word(model_pc)});
                    addrq.push_back(model_pc);
                    respq.push_back('{bus.imem_addr, epoch, cyc + int'($urandom_range(lat_max, lat_min))});
                    model_pc += 32'd4;
                end
                if (bus.redirect_valid) begin
                    expq.delete();
                    epoch++;
                    model_pc = bus.redirect_pc;
                end
            end
        end
    end

    // Monitor: compares what the DUT presents against the queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #3;
            if (rst) begin
                prev_redir = 0;
            end else begin
                chk("imem_req", 32'(bus.imem_req), 32'(exp_req));
                if (prev_redir) chk("id_valid_after_redirect", 32'(bus.id_valid), 32'd0);
                if (bus.imem_req && bus.imem_gnt) begin
                    if (addrq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL grant: unexpected grant of %h (cycle %0d)", bus.imem_addr, cyc);
                    end else chk("imem_addr", bus.imem_addr, addrq.pop_front());
                end
                if (bus.id_valid && bus.id_ready && !bus.redirect_valid) begin
                    if (expq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL decode: spurious entry pc %h, none expected (cycle %0d)", bus.id_pc, cyc);
                    end else begin
                        e = expq.pop_front();
                        chk("id_pc", bus.id_pc, e.pc);
                        chk("id_instr", bus.id_instr, e.instr);
                        chk("id_pc_4", bus.id_pc_4, e.pc + 32'd4);
                    end
                end
                prev_redir = bus.redirect_valid;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        #4;
        chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst_imem_addr", bus.imem_addr, RST_PC);
        chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
        chk("rst_id_instr", bus.id_instr, 32'd0);
        chk("rst_id_pc", bus.id_pc, 32'd0);
        chk("rst_id_pc_4", bus.id_pc_4, 32'd4);
        @(negedge clk);
        rst = 0;
        for (int k = 1; k <= 5; k++) begin
            #4;
            chk($sformatf("start_valid_%0d", k), 32'(bus.id_valid), 32'(k >= FIRST));
            if (k >= FIRST) chk($sformatf("start_pc_%0d", k), bus.id_pc, 32'((k - FIRST) * 4));
            if (k == 1) chk("first_req_addr", bus.imem_addr, RST_PC);
            @(negedge clk);
        end
        p_ready = 0;
        repeat (8) @(negedge clk);
        #4;
        chk("stall_imem_req", 32'(bus.imem_req), 32'd0);
        chk("stall_id_valid", 32'(bus.id_valid), 32'd1);
        p_ready = 100;
        repeat (10) @(negedge clk);
        p_ready = 0;
        repeat (8) @(negedge clk);
        @(posedge clk); #2;
        rst = 1;
        #1;
        chk("midrst_id_valid", 32'(bus.id_valid), 32'd0);
        chk("midrst_imem_req", 32'(bus.imem_req), 32'd0);
        chk("midrst_imem_addr", bus.imem_addr, RST_PC);
        repeat (2) @(negedge clk);
        p_ready = 100;
        rst = 0;
        wait_hs("restart_pc", RST_PC);
        lat_min = 3; lat_max = 3;
        repeat (6) @(negedge clk);
        @(posedge clk); #2;
        force_pc = 32'h100; force_redir = 1;
        wait_hs("redirect_pc", 32'h100);
        @(posedge clk); #2;
        force_pc = 32'hFFFF_FFF8; force_redir = 1;
        wait_hs("wrap_pc0", 32'hFFFF_FFF8);
        wait_hs("wrap_pc1", 32'hFFFF_FFFC);
        wait_hs("wrap_pc2", 32'h0);
        p_gnt = 70; p_ready = 70; p_redir = 8; p_rv = 80; lat_min = 1; lat_max = 4;
        repeat (3000) @(negedge clk);
        p_gnt = 0; p_redir = 0; p_ready = 100; p_rv = 100;
        for (int n = 0; n < 60 && expq.size() != 0; n++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("drain_left", expq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction fetch stage: generates sequential fetch addresses, talks to instruction memory over a variable-latency request/response handshake, and buffers returned instructions in a small FIFO. Decode consumes entries through a valid/ready handshake. A redirect from execute (branch/jump) flushes all buffered and in-flight fetches. Sits between the PC source and the decode stage, and replaces the fixed single-cycle fetch register.

## Interface
- XLEN, 32, address/instruction width
- RESET_PC, 0, first fetch address after reset
- FQ_DEPTH, 4, fetch queue entries (power of 2, ≥2)
- MAX_OUTSTANDING, 4, in-flight imem requests limit (≤ FQ_DEPTH)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- redirect_valid  in  1  taken branch/jump from execute
- redirect_pc  in  XLEN  new fetch address
- imem_req  out  1  request valid
- imem_addr  out  XLEN  request address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  in-order response valid
- imem_rdata  in  XLEN  response instruction
- id_valid  out  1  head entry valid
- id_ready  in  1  decode accepts head
- id_instr  out  XLEN  head instruction
- id_pc  out  XLEN  head PC
- id_pc_4  out  XLEN  id_pc + 4, modulo 2^XLEN

## Operation
- fetch_pc register: reset RESET_PC; +4 on each imem_req&&imem_gnt; wraps 0xFFFF_FFFC→0x0.
- imem_req = !rst && !redirect_valid && (q_count + outstanding < FQ_DEPTH) && (outstanding < MAX_OUTSTANDING); imem_addr = fetch_pc.
- imem_req, once raised, is held with a stable address until granted, unless a redirect occurs.
- outstanding: +1 on grant, −1 on rvalid; both in the same cycle → unchanged.
- Pending-PC FIFO (depth MAX_OUTSTANDING) holds the address of each granted request and pairs it with its response.
- Response (rvalid, not discarded) → pushes {rdata, pc} into the queue. The credit rule guarantees the queue never overflows; a push when full is an assertion failure.
- Pop on id_valid && id_ready. Push and pop in the same cycle → q_count unchanged.
- Redirect (cycle N):
  - queue cleared;
  - fetch_pc ← redirect_pc;
  - imem_req forced 0;
  - discard_cnt ← outstanding − (imem_rvalid ? 1 : 0);
  - a response arriving in cycle N is dropped.
- Redirect also resets the pending-PC FIFO pointers. Discarded responses do not consult it.
- While discard_cnt > 0, each rvalid decrements discard_cnt and is dropped. New grants may proceed meanwhile.
- Redirect in the same cycle as a decode handshake → redirect wins. Decode must squash its own copy.
- Back-to-back redirects: the latest redirect_pc wins; discard_cnt is recomputed each time.
- id_instr/id_pc/id_pc_4 are undefined when id_valid=0 but are driven from the head slot (zero after reset).

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, id_valid=0, id_instr=0, id_pc=0, id_pc_4=4, all counters 0.
- First request is raised in the first cycle after rst deasserts.
- Grant at cycle N with rvalid at cycle N+L (L≥1): id_valid rises at N+L+1 (registered queue; see Configuration).
- Steady state with L=1, id_ready=1, single-cycle grant: one instruction per cycle.
- Redirect at cycle N: first request to redirect_pc at N+1.
- Reset mid-operation clears everything immediately. Responses arriving after reset to pre-reset requests are a system error; imem is reset on the same rst.

## Configuration
- FETCH_BYPASS_EN defined: when the queue is empty, a non-discarded rvalid drives id_valid/id_instr/id_pc combinationally in the same cycle.
  - If id_ready=1, the entry is not written to the queue.
  - Latency: rvalid cycle equals id_valid cycle.
- Not defined: all responses go through the queue, with a one-cycle minimum latency from rvalid to id_valid.

## Structure
- fetch_pkg:
  - fetch_entry_t {instr, pc};
  - localparam PC_INC = 4;
  - function clog2-safe width helpers.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t, parametrised depth, with push, pop, flush, full, empty and count.
- The same sub-module is instantiated for the pending-PC FIFO.

## Test plan
- Reset release, gnt=1, L=1, id_ready=1 → imem_addr 0,4,8,…; id_pc 0,4,8 on consecutive cycles from cycle 3.
- id_ready=0 with FQ_DEPTH=4 → queue fills, imem_req drops after 4 credits used, no lost or duplicated PCs on release.
- 2 requests outstanding, redirect_pc=0x100 → both responses dropped, next id_pc=0x100, id_pc_4=0x104.
- Redirect coincident with rvalid and id handshake → discard_cnt = outstanding−1, queue empty next cycle.
- RESET_PC=0xFFFF_FFF8 → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; id_pc_4 of 0xFFFF_FFFC equals 0x0.
- rst asserted with 3 entries queued → id_valid=0 and imem_req=0 immediately; restarts at RESET_PC.
